// File: rtl/button_pkg.sv
// Shared LED mode encoding and the mode successor used by the button-driven LED sequencer.
package button_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  // Short presses walk the modes in a ring: OFF -> ON -> SLOW -> FAST -> OFF.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    unique case (cur)
      MODE_OFF:  nxt = MODE_ON;
      MODE_ON:   nxt = MODE_SLOW;
      MODE_SLOW: nxt = MODE_FAST;
      MODE_FAST: nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus hold-time debouncer for a raw push-button level.
// rise/fall flag the cycle in which the debounced level is about to flip.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic switch,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_q;
  logic             sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             settled;

  // The new level has been stable long enough; it is taken on the next edge.
  assign settled = (sync_q != level_q) && (cnt_q == CNT_LAST);
  assign rise    = settled & sync_q;
  assign fall    = settled & ~sync_q;
  assign level   = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_meta_q <= switch;
      sync_q      <= sync_meta_q;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (settled) begin
        level_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_led_ctrl.sv
// Push-button LED sequencer: short presses step OFF/ON/SLOW/FAST, a long press forces OFF.
// All outputs are registered; pulses are high while the new mode is already visible.
module button_led_ctrl
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000,
  parameter int unsigned SLOW_HALF_CYCLES  = 6000000,
  parameter int unsigned FAST_HALF_CYCLES  = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch,
  output logic       led,
  output logic [1:0] mode,
  output logic       short_press,
  output logic       long_press
);

  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  localparam int unsigned BLINK_HALF_MAX =
      (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ? SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF_MAX);
  localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF_CYCLES - 1);
  localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF_CYCLES - 1);

  logic               level;
  logic               rise;
  logic               fall;

  logic [HOLD_W-1:0]  hold_q;
  logic [BLINK_W-1:0] blink_q;
  logic               long_seen_q;
  mode_e              mode_q;
  logic               led_q;
  logic               short_q;
  logic               long_q;

  logic               long_hit;
  logic               short_hit;
  logic               mode_chg;
  mode_e              mode_nxt;
  logic               blink_last;
  logic               blinking;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .switch(switch),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    long_hit   = level && (hold_q == HOLD_LAST);
    // A release landing on the long-press cycle still counts as the long press.
    short_hit  = fall && !long_seen_q && !long_hit;
    mode_chg   = long_hit || short_hit;
    mode_nxt   = long_hit ? MODE_OFF : next_mode(mode_q);
    blinking   = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
    blink_last = (mode_q == MODE_SLOW) ? (blink_q == SLOW_LAST) : (blink_q == FAST_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (rise) begin
      hold_q <= '0;
    end else if (level && (hold_q != HOLD_MAX)) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      led_q       <= 1'b0;
      blink_q     <= '0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      long_seen_q <= 1'b0;
    end else begin
      short_q <= short_hit;
      long_q  <= long_hit;

      if (long_hit) begin
        long_seen_q <= ~fall;
      end else if (fall) begin
        long_seen_q <= 1'b0;
      end

      if (mode_chg) begin
        mode_q  <= mode_nxt;
        blink_q <= '0;
        led_q   <= (mode_nxt != MODE_OFF);
      end else if (blinking) begin
        if (blink_last) begin
          blink_q <= '0;
          led_q   <= ~led_q;
        end else begin
          blink_q <= blink_q + 1'b1;
        end
      end
    end
  end

  assign led         = led_q;
  assign mode        = mode_q;
  assign short_press = short_q;
  assign long_press  = long_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Scoreboard bench for button_led_ctrl with small timing parameters.
module tb_button_led_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned SLOW = 8;
  localparam int unsigned FAST = 2;

  logic       clk;
  logic       rst;
  logic       switch;
  logic       led;
  logic [1:0] mode;
  logic       short_press;
  logic       long_press;

  typedef struct {
    bit          is_long;
    int unsigned cyc;
    int unsigned mode;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned exp_mode = 0;
  int unsigned pushed_short = 0;
  int unsigned pushed_long = 0;
  int unsigned seen_short = 0;
  int unsigned seen_long = 0;

  button_led_ctrl #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .SLOW_HALF_CYCLES (SLOW),
    .FAST_HALF_CYCLES (FAST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .switch     (switch),
    .led        (led),
    .mode       (mode),
    .short_press(short_press),
    .long_press (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (short_press || long_press)) begin
      check_val("pulse_exclusive", {31'b0, short_press & long_press}, 0);
      if (short_press) seen_short++;
      if (long_press) seen_long++;
      check_val("pulse_expected", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("pulse_kind_long", {31'b0, long_press}, {31'b0, e.is_long});
        check_val("pulse_cycle", cyc, e.cyc);
        check_val("pulse_mode", {30'b0, mode}, e.mode);
        check_val("pulse_led", {31'b0, led}, {31'b0, e.mode != 0});
      end
    end
  end

  task automatic press(input int unsigned h, input int unsigned l);
    exp_t e;
    switch = 1'b1;
    if (h >= LONG) begin
      exp_mode = 0;
      e = '{1'b1, cyc + 2 + DEB + LONG, 0};
      sb.push_back(e);
      pushed_long++;
    end
    repeat (h) @(negedge clk);
    switch = 1'b0;
    if (h < LONG) begin
      exp_mode = (exp_mode + 1) % 4;
      e = '{1'b0, cyc + 2 + DEB, exp_mode};
      sb.push_back(e);
      pushed_short++;
    end
    repeat (l) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag);
    int unsigned n = 0;
    while (!(short_press || long_press) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'b0, short_press | long_press}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 10000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit rose;
    int unsigned n;

    rst    = 1'b1;
    switch = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_led", {31'b0, led}, 0);
    check_val("reset_mode", {30'b0, mode}, 0);
    check_val("reset_short", {31'b0, short_press}, 0);
    check_val("reset_long", {31'b0, long_press}, 0);

    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("held_after_reset_mode", {30'b0, mode}, 0);

    rst    = 1'b1;
    switch = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Bounce: 2-cycle glitches never outlast the debounce window.
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      switch = ~switch;
      repeat (2) begin
        @(negedge clk);
        if (dut.u_debounce.level) rose = 1'b1;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (dut.u_debounce.level) rose = 1'b1;
    end
    check_val("bounce_level_rose", {31'b0, rose}, 0);
    check_val("bounce_mode", {30'b0, mode}, 0);

    for (int i = 0; i < 4; i++) begin
      press(8, 8);
      check_val("short_seq_mode", {30'b0, mode}, exp_mode);
    end

    press(8, 8);
    press(8, 0);
    wait_pulse("slow_entry_pulse");
    for (int k = 0; k < 32; k++) begin
      check_val("slow_blink", {31'b0, led}, {31'b0, ((k / SLOW) % 2) == 0});
      @(negedge clk);
    end

    press(8, 0);
    wait_pulse("fast_entry_pulse");
    for (int k = 0; k < 16; k++) begin
      check_val("fast_blink", {31'b0, led}, {31'b0, ((k / FAST) % 2) == 0});
      @(negedge clk);
    end
    check_val("fast_mode", {30'b0, mode}, 3);

    press(30, 12);
    check_val("long_mode", {30'b0, mode}, 0);
    check_val("long_led", {31'b0, led}, 0);

    // Reset mid-hold: the still-held switch must re-debounce from scratch.
    switch = 1'b1;
    repeat (15) @(negedge clk);
    rst      = 1'b1;
    exp_mode = 0;
    repeat (2) @(negedge clk);
    check_val("midhold_reset_led", {31'b0, led}, 0);
    check_val("midhold_reset_mode", {30'b0, mode}, 0);
    rst = 1'b0;
    begin
      exp_t e;
      e = '{1'b1, cyc + 2 + DEB + LONG, 0};
      sb.push_back(e);
      pushed_long++;
    end
    repeat (30) @(negedge clk);
    switch = 1'b0;
    repeat (12) @(negedge clk);
    check_val("midhold_mode", {30'b0, mode}, 0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("scoreboard_drained", sb.size(), 0);
    check_val("short_count", seen_short, pushed_short);
    check_val("long_count", seen_long, pushed_long);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
